// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin IFU/LSU arbiter onto one memory port with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                timeout_err
);

  localparam int                c_MASK_W       = DATA_W / 8;
  localparam logic [7:0]        c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] c_TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_owner_lsu;
  logic                  r_last_lsu;
  logic [7:0]            r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_wen;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_MASK_W-1:0]   r_wmask;
  logic                  r_mem_req_valid;
  logic                  r_busy;
  logic                  r_timeout_err;
  logic                  r_ifu_resp_valid;
  logic                  r_lsu_resp_valid;
  logic [DATA_W-1:0]     r_ifu_rdata;
  logic [DATA_W-1:0]     r_lsu_rdata;

  logic                  w_grant_lsu;
  logic                  w_resp_hit;
  logic                  w_expire;
  logic [DATA_W-1:0]     w_fin_data;

  // On a tie the requester that did not win last time is served.
  assign w_grant_lsu = lsu_reqValid & (~ifu_reqValid | ~r_last_lsu);
  assign w_resp_hit  = ((r_state == S_REQ) & mem_reqReady & mem_respValid) |
                       ((r_state == S_WAIT) & mem_respValid);
  // A response landing on the expiry cycle takes priority over the watchdog.
  assign w_expire    = ((r_state == S_REQ) | (r_state == S_WAIT)) & ~w_resp_hit &
                       (r_cnt == c_TIMEOUT_LAST);
  assign w_fin_data  = w_expire ? c_TIMEOUT_DATA : (r_wen ? '0 : mem_rdata);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_owner_lsu      <= 1'b0;
      r_last_lsu       <= 1'b0;
      r_cnt            <= '0;
      r_addr           <= '0;
      r_wen            <= 1'b0;
      r_wdata          <= '0;
      r_wmask          <= '0;
      r_mem_req_valid  <= 1'b0;
      r_busy           <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_ifu_rdata      <= '0;
      r_lsu_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ifu_reqValid || lsu_reqValid) begin
            r_owner_lsu     <= w_grant_lsu;
            r_last_lsu      <= w_grant_lsu;
            r_addr          <= w_grant_lsu ? lsu_addr : ifu_addr;
            r_wen           <= w_grant_lsu & lsu_wen;
            r_wdata         <= w_grant_lsu ? lsu_wdata : '0;
            r_wmask         <= w_grant_lsu ? lsu_wmask : '0;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_resp_hit || w_expire) begin
            r_mem_req_valid <= 1'b0;
            r_timeout_err   <= r_timeout_err | w_expire;
            if (r_owner_lsu) begin
              r_lsu_resp_valid <= 1'b1;
              r_lsu_rdata      <= w_fin_data;
            end else begin
              r_ifu_resp_valid <= 1'b1;
              r_ifu_rdata      <= w_fin_data;
            end
            r_state <= S_RESP;
          end else if ((r_state == S_REQ) && mem_reqReady) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_WAIT;
          end
        end
        S_RESP: begin
          r_ifu_resp_valid <= 1'b0;
          r_lsu_resp_valid <= 1'b0;
          r_busy           <= 1'b0;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifu_respValid = r_ifu_resp_valid;
  assign ifu_rdata     = r_ifu_rdata;
  assign lsu_respValid = r_lsu_resp_valid;
  assign lsu_rdata     = r_lsu_rdata;
  assign mem_reqValid  = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the first REQ cycle; returns in the RESP cycle.
  task automatic serve(input logic [31:0] rd, input bit fast);
    mem_rdata = rd;
    if (fast) begin
      mem_reqReady = 1'b1; mem_respValid = 1'b1;
      tick();
      mem_reqReady = 1'b0; mem_respValid = 1'b0;
    end else begin
      mem_reqReady = 1'b1;
      tick();
      mem_reqReady = 1'b0; mem_respValid = 1'b1;
      tick();
      mem_respValid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    ifu_reqValid = 0; ifu_addr = 0;
    lsu_reqValid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_reqReady = 0; mem_respValid = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_reqValid", mem_reqValid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ifu_rdata", ifu_rdata, 0);
    reset = 1'b1;
    tick();

    // Single fetch through WAIT.
    ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
    tick();
    chk("fetch_reqValid", mem_reqValid, 1);
    chk("fetch_addr", mem_addr, 32'h8000_0000);
    chk("fetch_wen", mem_wen, 0);
    chk("fetch_busy", busy, 1);
    mem_reqReady = 1;
    tick();
    chk("fetch_wait_reqValid", mem_reqValid, 0);
    chk("fetch_wait_resp", ifu_respValid, 0);
    mem_reqReady = 0; mem_respValid = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_respValid = 0;
    chk("fetch_ifu_resp", ifu_respValid, 1);
    chk("fetch_ifu_rdata", ifu_rdata, 32'h0000_0013);
    chk("fetch_lsu_resp", lsu_respValid, 0);
    ifu_reqValid = 0;
    tick();
    chk("fetch_pulse_end", ifu_respValid, 0);
    chk("fetch_idle_busy", busy, 0);
    chk("fetch_rdata_hold", ifu_rdata, 32'h0000_0013);

    // Store: read data must come back as zero.
    lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h100;
    lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'b0011;
    tick();
    chk("store_addr", mem_addr, 32'h100);
    chk("store_wen", mem_wen, 1);
    chk("store_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("store_wmask", 32'(mem_wmask), 32'h3);
    serve(32'h1234_5678, 0);
    chk("store_lsu_resp", lsu_respValid, 1);
    chk("store_lsu_rdata", lsu_rdata, 0);
    chk("store_ifu_resp", ifu_respValid, 0);
    lsu_reqValid = 0; lsu_wen = 0; lsu_wmask = 0;
    tick();

    // Ties from reset alternate LSU, IFU, LSU, IFU; all served on the fast path.
    reset = 0; tick(); reset = 1; tick();
    lsu_addr = 32'h200; ifu_addr = 32'h300;
    lsu_reqValid = 1; ifu_reqValid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("tie%0d_addr", i), mem_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
      chk($sformatf("tie%0d_early", i), 32'({ifu_respValid, lsu_respValid}), 0);
      serve(32'hAAAA_0000 + 32'(i), 1);
      chk($sformatf("tie%0d_lsu_resp", i), lsu_respValid, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("tie%0d_ifu_resp", i), ifu_respValid, (i % 2 == 0) ? 1'b0 : 1'b1);
      tick();
    end
    chk("tie_lsu_rdata", lsu_rdata, 32'hAAAA_0002);
    chk("tie_ifu_rdata", ifu_rdata, 32'hAAAA_0003);
    lsu_reqValid = 0; ifu_reqValid = 0;
    tick();

    // Backpressure: request held stable for six cycles.
    ifu_reqValid = 1; ifu_addr = 32'h400;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d_reqValid", i), mem_reqValid, 1);
      chk($sformatf("bp%0d_addr", i), mem_addr, 32'h400);
      chk($sformatf("bp%0d_busy", i), busy, 1);
      if (i < 5) tick();
    end
    serve(32'h0BAD_F00D, 1);
    chk("bp_ifu_resp", ifu_respValid, 1);
    chk("bp_ifu_rdata", ifu_rdata, 32'h0BAD_F00D);
    ifu_reqValid = 0;
    tick();

    // Watchdog: eight REQ cycles with no ready.
    lsu_reqValid = 1; lsu_addr = 32'h500;
    tick();
    for (int i = 1; i < 8; i++) tick();
    chk("to_still_req", mem_reqValid, 1);
    chk("to_no_err_yet", timeout_err, 0);
    tick();
    chk("to_lsu_resp", lsu_respValid, 1);
    chk("to_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("to_err", timeout_err, 1);
    chk("to_reqValid_drop", mem_reqValid, 0);
    lsu_reqValid = 0;
    tick();

    // Normal fetch after timeout; error stays sticky.
    ifu_reqValid = 1; ifu_addr = 32'h600;
    tick();
    serve(32'h0000_0055, 0);
    chk("post_to_rdata", ifu_rdata, 32'h0000_0055);
    chk("post_to_err", timeout_err, 1);
    ifu_reqValid = 0;
    tick();

    // Response on the expiry cycle wins over the watchdog.
    lsu_reqValid = 1; lsu_addr = 32'h700;
    tick();
    for (int i = 1; i < 8; i++) tick();
    serve(32'hCAFE_0001, 1);
    chk("race_lsu_resp", lsu_respValid, 1);
    chk("race_lsu_rdata", lsu_rdata, 32'hCAFE_0001);
    lsu_reqValid = 0;
    tick();

    // Asynchronous reset in the middle of REQ.
    ifu_reqValid = 1; ifu_addr = 32'h800;
    tick();
    chk("arst_pre_reqValid", mem_reqValid, 1);
    reset = 0;
    #1;
    chk("arst_reqValid", mem_reqValid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_err", timeout_err, 0);
    chk("arst_rdata", ifu_rdata, 0);
    ifu_reqValid = 0;
    tick();
    chk("arst_no_resp", ifu_respValid, 0);
    reset = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- The control state machine raises ifu_reqValid and lsu_reqValid as levels and waits for the matching respValid pulse. This block picks a winner, drives one memory transaction at a time, and returns the response to the owner.
- Round-robin arbitration between the two requesters, one outstanding transaction, and a watchdog that completes hung transactions with an error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the byte mask is DATA_W/8 bits.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before forced completion; the counter is 8 bits wide.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ifu_reqValid  in  1  IFU fetch request, level; held until ifu_respValid.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_respValid  out  1  one-cycle response pulse to the IFU.
- ifu_rdata  out  DATA_W  fetched word; valid when ifu_respValid=1.
- lsu_reqValid  in  1  LSU request, level; held until lsu_respValid.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte enables.
- lsu_respValid  out  1  one-cycle response pulse to the LSU.
- lsu_rdata  out  DATA_W  load data; 0 for stores.
- mem_reqValid  out  1  memory request valid.
- mem_reqReady  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  latched address.
- mem_wen  out  1  latched write enable.
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  DATA_W/8  latched byte mask.
- mem_respValid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 whenever state != IDLE.
- timeout_err  out  1  sticky; set on watchdog expiry and cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output and latch = 0; last_grant=IFU, so LSU wins the first tie.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Requests are sampled at the clock edge.
  - Only one request: that requester wins.
  - Both requests: the requester other than last_grant wins.
  - On grant, latch owner, addr, wen, wdata, wmask and update last_grant. An IFU grant forces wen=0 and wmask=0.
  - Go to REQ. With no request, stay in IDLE.
- REQ:
  - mem_reqValid=1, mem_* outputs driven from the latches and stable until accepted.
  - mem_reqReady=1 and mem_respValid=1 in the same cycle: capture rdata, go to RESP.
  - mem_reqReady=1 alone: go to WAIT.
- WAIT:
  - mem_reqValid=0.
  - mem_respValid=1: capture mem_rdata (forced to 0 when wen=1), go to RESP.
  - mem_respValid seen in IDLE or RESP is ignored.
- RESP:
  - The owner's respValid=1 for exactly one cycle, with its rdata driven from the latch; the other requester's respValid=0.
  - Next state is always IDLE; requests are not sampled in RESP.
  - The requester drops reqValid combinationally on seeing respValid, so the next fetch is arbitrated in IDLE one cycle later.
- rdata outputs hold their last value between pulses.
- Latency: request at cycle N, mem_reqValid at N+1, ready at N+1, mem_respValid at N+2, owner respValid at N+3. Minimum is 2 cycles when ready and response coincide at N+1.
- Watchdog:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: drop mem_reqValid, set timeout_err, latch rdata=32'hDEADBEEF, go to RESP.
  - A response arriving in the same cycle as expiry wins: no error is flagged.
- Requests never preempt an in-flight transaction. A requester that drops reqValid mid-transaction still receives its respValid pulse.
- Reset mid-transaction aborts immediately: no respValid, and mem_reqValid=0 asynchronously.

Test Plan:
- Single fetch: ifu_reqValid=1, ifu_addr=0x80000000; memory ready at N+1, mem_rdata=0x00000013 at N+2 -> mem_addr=0x80000000, mem_wen=0; ifu_respValid pulses at N+3 with ifu_rdata=0x00000013; lsu_respValid stays 0.
- Store: lsu_wen=1, lsu_addr=0x100, lsu_wdata=0xA5A5A5A5, lsu_wmask=4'b0011 -> mem_* carry the same values; lsu_respValid pulses; lsu_rdata=0.
- Tie from reset: both requests in the same cycle -> LSU served first, IFU second. Repeat the tie -> grants alternate (LSU, IFU, LSU, IFU).
- Backpressure: mem_reqReady held 0 for 5 cycles -> mem_reqValid and mem_addr stay stable for 6 cycles; busy=1 throughout.
- Fast path: mem_reqReady=1 and mem_respValid=1 in the same cycle -> respValid 2 cycles after the request; WAIT is skipped.
- Timeout with TIMEOUT=8: memory never ready -> after 8 cycles in REQ, owner respValid pulses with rdata=0xDEADBEEF and timeout_err=1. A following transaction completes normally and timeout_err stays 1. Asserting reset=0 mid-REQ -> all outputs 0 immediately.
